// File: rtl/serial_stream_tx.sv
// serial_stream_tx
// Host-to-device serial transmitter. Words written through a pipe-in
// (wr_en/din) are buffered in a FIFO and shifted out on serial_out at one
// bit per ti_clk. frame_sync marks the first bit of every word. Words
// stream back-to-back while tx_enable is high and the FIFO has data.
//
// Ports:
//   ti_clk          sole clock (host interface clock)
//   reset           asynchronous, active-high reset
//   wr_en, din      FIFO write strobe and data
//   tx_enable       permits starting new words (never truncates a word)
//   full, empty     registered FIFO status flags
//   fifo_count      registered FIFO occupancy
//   overflow        sticky flag: a write arrived while full and was dropped
//   underrun_count  saturating count of word boundaries that found no data
//   serial_out      serial data, IDLE_LEVEL when nothing is shifting
//   frame_sync      high during the first bit of each word
//   busy            high while a word is being shifted
module serial_stream_tx #(
   parameter int WORD_WIDTH = 16,
   parameter int FIFO_DEPTH = 16,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic                          ti_clk,
   input  logic                          reset,
   input  logic                          wr_en,
   input  logic [WORD_WIDTH-1:0]         din,
   input  logic                          tx_enable,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic [15:0]                   underrun_count,
   output logic                          serial_out,
   output logic                          frame_sync,
   output logic                          busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } state_t;

   state_t                  state_q, state_d;
   logic [WORD_WIDTH-1:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    full_q, full_d;
   logic                    empty_q, empty_d;
   logic                    overflow_q, overflow_d;
   logic [15:0]             underrun_q, underrun_d;
   logic [WORD_WIDTH-1:0]   shift_q, shift_d;
   logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
   logic                    serial_out_q, serial_out_d;
   logic                    frame_sync_q, frame_sync_d;
   logic                    busy_q, busy_d;
   logic                    push;
   logic                    pop;
   logic [WORD_WIDTH-1:0]   head;

   // A write is only accepted against the registered full flag, so a pop on
   // the same edge cannot make room for it.
   assign push = wr_en && !full_q;
   assign head = mem_q[rd_ptr_q];

   // FIFO storage has no reset; occupancy is tracked by the pointers and
   // count, so stale contents are never observed.
   always_ff @(posedge ti_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   // FIFO bookkeeping. Pointers wrap naturally because the depth is a power
   // of two. full/empty are derived from the next count so they are
   // registered alongside it and always agree with fifo_count.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (wr_en && full_q) begin
         overflow_d = 1'b1;
      end
      full_d  = (count_d == CW'(FIFO_DEPTH));
      empty_d = (count_d == '0);
   end

   // Transmit state machine. The shift register holds only the bits still
   // to be sent, so the outgoing bit is always taken from the same end.
   // A new word is loaded either from IDLE or on the edge that ends the last
   // bit of the current word, which gives gap-free back-to-back streaming.
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      serial_out_d = serial_out_q;
      frame_sync_d = 1'b0;
      busy_d       = busy_q;
      underrun_d   = underrun_q;
      pop          = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (tx_enable && !empty_q) begin
               pop = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (bit_cnt_q != BW'(WORD_WIDTH - 1)) begin
               bit_cnt_d = bit_cnt_q + BW'(1);
               if (MSB_FIRST) begin
                  serial_out_d = shift_q[WORD_WIDTH-1];
                  shift_d      = shift_q << 1;
               end else begin
                  serial_out_d = shift_q[0];
                  shift_d      = shift_q >> 1;
               end
            end else if (tx_enable && !empty_q) begin
               pop = 1'b1;
            end else begin
               if (tx_enable && (underrun_q != 16'hFFFF)) begin
                  underrun_d = underrun_q + 16'd1;
               end
               state_d      = ST_IDLE;
               serial_out_d = IDLE_LEVEL;
               busy_d       = 1'b0;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            serial_out_d = IDLE_LEVEL;
            busy_d       = 1'b0;
         end
      endcase

      if (pop) begin
         state_d      = ST_SHIFT;
         bit_cnt_d    = '0;
         busy_d       = 1'b1;
         frame_sync_d = 1'b1;
         if (MSB_FIRST) begin
            serial_out_d = head[WORD_WIDTH-1];
            shift_d      = head << 1;
         end else begin
            serial_out_d = head[0];
            shift_d      = head >> 1;
         end
      end
   end

   // State registers. Reset aborts any word in flight immediately; the
   // partially sent word is lost along with the FIFO contents.
   always_ff @(posedge ti_clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
         overflow_q   <= 1'b0;
         underrun_q   <= '0;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         serial_out_q <= IDLE_LEVEL;
         frame_sync_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         full_q       <= full_d;
         empty_q      <= empty_d;
         overflow_q   <= overflow_d;
         underrun_q   <= underrun_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         serial_out_q <= serial_out_d;
         frame_sync_q <= frame_sync_d;
         busy_q       <= busy_d;
      end
   end

   assign full           = full_q;
   assign empty          = empty_q;
   assign fifo_count     = count_q;
   assign overflow       = overflow_q;
   assign underrun_count = underrun_q;
   assign serial_out     = serial_out_q;
   assign frame_sync     = frame_sync_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_serial_stream_tx.sv
// tb_serial_stream_tx
// Self-checking bench for serial_stream_tx. A queue-based reference model
// tracks the FIFO contents and the bits still owed on the serial line; every
// cycle the DUT outputs are compared against it, and directed scenarios add
// fixed expected values on top.
module tb_serial_stream_tx;

   localparam int WW      = 16;
   localparam int DEPTH   = 16;
   localparam bit MSB_1ST = 1'b1;
   localparam bit IDLE_LV = 1'b0;

   logic          ti_clk;
   logic          reset;
   logic          wr_en;
   logic [WW-1:0] din;
   logic          tx_enable;
   logic          full;
   logic          empty;
   logic [4:0]    fifo_count;
   logic          overflow;
   logic [15:0]   underrun_count;
   logic          serial_out;
   logic          frame_sync;
   logic          busy;

   int compared;
   int mismatched;

   logic [WW-1:0] m_fifo[$];
   bit            m_bits[$];
   bit            m_active;
   bit            m_out;
   bit            m_fs;
   bit            m_ovf;
   int            m_under;

   logic [47:0]   data_vec;
   logic [47:0]   fs_vec;
   bit            en_r;
   int            thr;

   serial_stream_tx #(
      .WORD_WIDTH (WW),
      .FIFO_DEPTH (DEPTH),
      .MSB_FIRST  (MSB_1ST),
      .IDLE_LEVEL (IDLE_LV)
   ) dut (
      .ti_clk         (ti_clk),
      .reset          (reset),
      .wr_en          (wr_en),
      .din            (din),
      .tx_enable      (tx_enable),
      .full           (full),
      .empty          (empty),
      .fifo_count     (fifo_count),
      .overflow       (overflow),
      .underrun_count (underrun_count),
      .serial_out     (serial_out),
      .frame_sync     (frame_sync),
      .busy           (busy)
   );

   // Free-running 100 MHz host clock.
   initial begin
      ti_clk = 1'b0;
      forever #5 ti_clk = ~ti_clk;
   end

   // Single comparison point: counts it, and reports tag/observed/expected
   // when it does not hold.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every DUT output against the reference model.
   task automatic checkAllOutputs(input string tag);
      checkOutput({tag, ".serial_out"}, 32'(serial_out), 32'(m_out));
      checkOutput({tag, ".frame_sync"}, 32'(frame_sync), 32'(m_fs));
      checkOutput({tag, ".busy"}, 32'(busy), 32'(m_active));
      checkOutput({tag, ".fifo_count"}, 32'(fifo_count), 32'(m_fifo.size()));
      checkOutput({tag, ".full"}, 32'(full), 32'(m_fifo.size() == DEPTH));
      checkOutput({tag, ".empty"}, 32'(empty), 32'(m_fifo.size() == 0));
      checkOutput({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
      checkOutput({tag, ".underrun"}, 32'(underrun_count), 32'(m_under));
   endtask

   // Reference model reset: everything emptied, line idle.
   task automatic modelReset();
      m_fifo.delete();
      m_bits.delete();
      m_active = 1'b0;
      m_out    = IDLE_LV;
      m_fs     = 1'b0;
      m_ovf    = 1'b0;
      m_under  = 0;
   endtask

   // Reference model for one clock edge. While bits of the current word
   // remain they go out one by one; at a word boundary the next word is
   // taken from the queue if enabled and available, otherwise the line goes
   // idle (counting a starved boundary only when still enabled). Writes are
   // judged against the occupancy seen before the edge.
   task automatic modelStep(input bit wr, input logic [WW-1:0] d, input bit en);
      bit            pre_full;
      bit            pre_empty;
      logic [WW-1:0] w;
      pre_full  = (m_fifo.size() == DEPTH);
      pre_empty = (m_fifo.size() == 0);
      if (m_active && m_bits.size() > 0) begin
         m_out = m_bits.pop_front();
         m_fs  = 1'b0;
      end else if (en && !pre_empty) begin
         w = m_fifo.pop_front();
         for (int i = 0; i < WW; i++) begin
            m_bits.push_back(MSB_1ST ? w[WW-1-i] : w[i]);
         end
         m_out    = m_bits.pop_front();
         m_fs     = 1'b1;
         m_active = 1'b1;
      end else begin
         if (m_active && en && m_under < 65535) begin
            m_under++;
         end
         m_active = 1'b0;
         m_out    = IDLE_LV;
         m_fs     = 1'b0;
      end
      if (wr) begin
         if (pre_full) begin
            m_ovf = 1'b1;
         end else begin
            m_fifo.push_back(d);
         end
      end
   endtask

   // Drive one cycle of inputs, advance model and DUT by one edge, then
   // check all outputs shortly after the edge.
   task automatic applyStimulus(input bit wr, input logic [WW-1:0] d, input bit en, input string tag);
      wr_en     = wr;
      din       = d;
      tx_enable = en;
      @(posedge ti_clk);
      modelStep(wr, d, en);
      #1;
      checkAllOutputs(tag);
   endtask

   // Assert reset between edges, check it takes effect at once, then
   // release it away from the clock edge.
   task automatic doReset(input string tag);
      wr_en     = 1'b0;
      tx_enable = 1'b0;
      reset     = 1'b1;
      #2;
      modelReset();
      checkAllOutputs(tag);
      @(posedge ti_clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b1;
      wr_en      = 1'b0;
      din        = '0;
      tx_enable  = 1'b0;
      modelReset();
      repeat (2) @(posedge ti_clk);
      #1;
      checkAllOutputs("power_on_reset");
      reset = 1'b0;

      $display("[TB] single word 16'hA5C3");
      applyStimulus(1'b1, 16'hA5C3, 1'b1, "a5c3_write");
      data_vec = '0;
      fs_vec   = '0;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, '0, 1'b1, "a5c3_bit");
         data_vec = {data_vec[46:0], serial_out};
         fs_vec   = {fs_vec[46:0], frame_sync};
      end
      checkOutput("a5c3_stream", 32'(data_vec[15:0]), 32'h0000_A5C3);
      checkOutput("a5c3_fsync", 32'(fs_vec[15:0]), 32'h0000_8000);
      checkOutput("a5c3_busy_last", 32'(busy), 32'd1);
      applyStimulus(1'b0, '0, 1'b1, "a5c3_end");
      checkOutput("a5c3_busy_drop", 32'(busy), 32'd0);
      checkOutput("a5c3_underrun", 32'(underrun_count), 32'd1);

      $display("[TB] three preloaded words back to back");
      doReset("reset_2");
      applyStimulus(1'b1, 16'h0001, 1'b0, "pre_w0");
      applyStimulus(1'b1, 16'h8000, 1'b0, "pre_w1");
      applyStimulus(1'b1, 16'hFFFF, 1'b0, "pre_w2");
      data_vec = '0;
      fs_vec   = '0;
      for (int i = 0; i < 48; i++) begin
         applyStimulus(1'b0, '0, 1'b1, "pre_bit");
         data_vec = {data_vec[46:0], serial_out};
         fs_vec   = {fs_vec[46:0], frame_sync};
      end
      checkOutput("pre_stream_hi", 32'(data_vec[47:32]), 32'h0000_0001);
      checkOutput("pre_stream_lo", data_vec[31:0], 32'h8000_FFFF);
      checkOutput("pre_fsync_hi", 32'(fs_vec[47:32]), 32'h0000_8000);
      checkOutput("pre_fsync_lo", fs_vec[31:0], 32'h8000_8000);
      applyStimulus(1'b0, '0, 1'b1, "pre_end");
      checkOutput("pre_underrun", 32'(underrun_count), 32'd1);
      checkOutput("pre_empty", 32'(empty), 32'd1);

      $display("[TB] overflow with 17 writes");
      doReset("reset_3");
      for (int i = 1; i <= 17; i++) begin
         applyStimulus(1'b1, 16'(i * 16'h0101), 1'b0, "ovf_write");
      end
      checkOutput("ovf_full", 32'(full), 32'd1);
      checkOutput("ovf_count", 32'(fifo_count), 32'd16);
      checkOutput("ovf_flag", 32'(overflow), 32'd1);
      for (int i = 0; i < 16 * 16 + 2; i++) begin
         applyStimulus(1'b0, '0, 1'b1, "ovf_drain");
      end
      checkOutput("ovf_drain_underrun", 32'(underrun_count), 32'd1);

      $display("[TB] write while full on a pop edge");
      doReset("reset_4");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 16'($urandom), 1'b0, "fullpop_fill");
      end
      applyStimulus(1'b1, 16'h1234, 1'b1, "fullpop_edge");
      checkOutput("fullpop_count", 32'(fifo_count), 32'd15);
      checkOutput("fullpop_ovf", 32'(overflow), 32'd1);
      checkOutput("fullpop_fsync", 32'(frame_sync), 32'd1);

      $display("[TB] tx_enable dropped mid-word");
      doReset("reset_5");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 16'($urandom), 1'b0, "drop_fill");
      end
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, '0, 1'b1, "drop_bits0to5");
      end
      for (int i = 0; i < 13; i++) begin
         applyStimulus(1'b0, '0, 1'b0, "drop_finish");
      end
      checkOutput("drop_busy", 32'(busy), 32'd0);
      checkOutput("drop_line", 32'(serial_out), 32'd0);
      checkOutput("drop_count", 32'(fifo_count), 32'd2);
      checkOutput("drop_underrun", 32'(underrun_count), 32'd0);

      $display("[TB] reset mid-word");
      doReset("reset_6");
      applyStimulus(1'b1, 16'hFFFF, 1'b0, "midrst_w0");
      applyStimulus(1'b1, 16'h7777, 1'b0, "midrst_w1");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, '0, 1'b1, "midrst_bits");
      end
      checkOutput("midrst_pre_line", 32'(serial_out), 32'd1);
      doReset("midrst_abort");
      applyStimulus(1'b1, 16'h3C5A, 1'b1, "midrst_rewrite");
      for (int i = 0; i < 18; i++) begin
         applyStimulus(1'b0, '0, 1'b1, "midrst_stream");
      end

      $display("[TB] randomized traffic");
      doReset("reset_7");
      en_r = 1'b1;
      for (int blk = 0; blk < 8; blk++) begin
         thr = int'($urandom_range(0, 15));
         for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 19) == 0) begin
               en_r = ~en_r;
            end
            applyStimulus(($urandom_range(0, 15) < thr), 16'($urandom), en_r, "rand");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
